// File: rtl/highLowCpuPkg.sv
// rtl/highLowCpuPkg.sv - instruction encoding shared by the high/low CPU and its sequencer
package highLowCpuPkg;

  typedef enum logic [2:0] {
    COPY     = 3'd0,
    NOT      = 3'd1,
    AND      = 3'd2,
    OR       = 3'd3,
    ADD      = 3'd4,
    SUB      = 3'd5,
    CLASSIFY = 3'd6,
    SWAP     = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    ZERO        = 3'd0,
    INPUT_LOW   = 3'd1,
    INPUT_HIGH  = 3'd2,
    OUTPUT_LOW  = 3'd3,
    OUTPUT_HIGH = 3'd4,
    REG_A       = 3'd5,
    REG_B       = 3'd6,
    REG_C       = 3'd7
  } operand_t;

  typedef struct packed {
    opcode_t  opcode;
    operand_t src1;
    operand_t src2;
    operand_t dst;
  } instr_t;

  // COPY ZERO -> ZERO: architecturally a no-op, safe to feed the CPU at any time
  localparam instr_t IDLE_INSTR = '{opcode: COPY, src1: ZERO, src2: ZERO, dst: ZERO};

endpackage

// File: rtl/high_low_instr_seq.sv
// rtl/high_low_instr_seq.sv - program store and issue sequencer feeding the high/low CPU
// Define HIGH_LOW_SEQ_LOOP_EN to wrap to pc 0 after the last instruction instead of halting.
module high_low_instr_seq
  import highLowCpuPkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  output logic          load_ready,
  input  instr_t        load_instr,
  input  logic          load_last,
  input  logic          start,
  input  logic          stop,
  input  logic          clear,
  output instr_t        instr_o,
  output logic [AW-1:0] pc_o,
  output logic [AW:0]   prog_len_o,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    RUN   = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t        state_q;
  state_t        state_d;
  instr_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic          load_fire;
  logic          load_done;
  logic          last_issued;
  logic          issue_en;
  logic [AW-1:0] issue_pc;

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == RUN);
  assign done       = (state_q == HALT);

  // reset and clear both outrank a load, so neither may leave a half-written entry
  assign load_fire   = load_valid && load_ready && !clear && !reset;
  assign load_done   = load_fire && (load_last || (wr_ptr == AW'(DEPTH - 1)));
  assign last_issued = ({1'b0, pc_o} == (prog_len_o - (AW+1)'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    issue_en = 1'b0;
    issue_pc = '0;
    case (state_q)
      IDLE: begin
        if (load_done) begin
          state_d = READY;
        end
      end
      READY, HALT: begin
        if (start) begin
          state_d  = RUN;
          issue_en = 1'b1;
          issue_pc = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = READY;
        end else if (last_issued) begin
`ifdef HIGH_LOW_SEQ_LOOP_EN
          issue_en = 1'b1;
          issue_pc = '0;
`else
          state_d = HALT;
`endif
        end else begin
          issue_en = 1'b1;
          issue_pc = pc_o + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d  = IDLE;
      issue_en = 1'b0;
      issue_pc = '0;
    end
  end

  // Store contents survive reset, stop and halt; only an accepted load rewrites an entry
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem[wr_ptr] <= load_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr     <= '0;
      prog_len_o <= '0;
      pc_o       <= '0;
      instr_o    <= IDLE_INSTR;
    end else begin
      if (load_fire) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (load_done) begin
        prog_len_o <= {1'b0, wr_ptr} + (AW+1)'(1);
      end
      if (issue_en) begin
        instr_o <= mem[issue_pc];
        pc_o    <= issue_pc;
      end else begin
        instr_o <= IDLE_INSTR;
        pc_o    <= '0;
      end
    end
  end

endmodule

// File: doc/high_low_instr_seq.md
HIGH_LOW_INSTR_SEQ -- requirements
Module: high_low_instr_seq

Interface
REQ-001 Parameter DEPTH, default 16: program store entries; power of two, 2..256.
REQ-002 Parameter AW, default $clog2(DEPTH): address width.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous reset, active-high.
REQ-005 load_valid  input  1  load_instr is offered.
REQ-006 load_ready  output  1  sequencer accepts a load this cycle.
REQ-007 load_instr  input  $bits(instr_t)  instruction to store (highLowCpuPkg::instr_t).
REQ-008 load_last  input  1  qualifies load_valid: final instruction of the program.
REQ-009 start  input  1  begin issuing the stored program.
REQ-010 stop  input  1  abort issuing; return to READY.
REQ-011 clear  input  1  discard the program; return to IDLE.
REQ-012 instr_o  output  $bits(instr_t)  instruction driven to the CPU instr input.
REQ-013 pc_o  output  AW  store address of the instruction currently on instr_o.
REQ-014 prog_len_o  output  AW+1  number of stored instructions.
REQ-015 busy  output  1  high in RUN.
REQ-016 done  output  1  high in HALT.

Function
REQ-017 FSM states SHALL be IDLE, READY, RUN and HALT; load_ready SHALL be 1 only in IDLE.
REQ-018 Load handshake: transfer when load_valid && load_ready; store at wr_ptr, wr_ptr increments by 1.
REQ-019 Transfer with load_last=1, or transfer into address DEPTH-1: IDLE->READY, prog_len_o = wr_ptr+1 (DEPTH when full).
REQ-020 load_valid outside IDLE SHALL be ignored; store contents unchanged.
REQ-021 Idle instruction SHALL be opcode COPY, src1 ZERO, src2 ZERO, dst ZERO (no architectural effect); instr_o SHALL carry it in every state except RUN.
REQ-022 READY or HALT with start=1, clear=0: -> RUN, pc=0; mem[0] on instr_o in the cycle after start (1-cycle latency, instr_o registered).
REQ-023 RUN: one instruction per cycle, pc increments by 1; instr_o = mem[pc], pc_o = pc.
REQ-024 RUN with pc = prog_len_o-1 issued, no stop: behaviour per REQ-034/REQ-035.
REQ-025 RUN with stop=1: -> READY; instr_o = idle instruction the next cycle; an instruction already on instr_o completes its cycle.
REQ-026 clear=1 in any state: -> IDLE, wr_ptr=0, prog_len_o=0, idle instruction the next cycle; clear SHALL take priority over start, stop and load.
REQ-027 start in IDLE or RUN SHALL be ignored; stop outside RUN SHALL be ignored.
REQ-028 Store contents SHALL be retained across stop, HALT and restart; only a new load sequence overwrites them.
REQ-029 pc arithmetic SHALL be modulo DEPTH; pc never indexes >= prog_len_o.

Reset
REQ-030 reset SHALL take priority over all inputs.
REQ-031 Reset values: state IDLE, wr_ptr 0, pc 0, prog_len_o 0, instr_o idle instruction, busy 0, done 0, load_ready 1 (first cycle after reset).
REQ-032 Store contents SHALL not be reset; reset mid-RUN drops to IDLE the next cycle.
REQ-033 No output SHALL depend combinationally on reset.

Configuration
REQ-034 Macro HIGH_LOW_SEQ_LOOP_EN defined: after pc = prog_len_o-1, pc wraps to 0 and RUN continues; HALT is unreachable except via none (done stays 0); only stop, clear or reset leave RUN.
REQ-035 Macro HIGH_LOW_SEQ_LOOP_EN undefined: after pc = prog_len_o-1 is issued, -> HALT the next cycle; instr_o = idle instruction, done = 1, busy = 0.

Verification
REQ-036 Load 3 instrs (COPY INPUT_LOW->OUTPUT_LOW, NOT REG_A->REG_B, CLASSIFY INPUT_HIGH->REG_C, last on 3rd), start -> instr_o sequence idx 0,1,2 on cycles +1..+3, pc_o 0,1,2, prog_len_o 3; no-loop: done=1 on cycle +4; loop: idx 0 on cycle +4.
REQ-037 DEPTH=16, 16 loads without load_last -> READY after 16th, prog_len_o 16, load_ready 0; 17th load_valid ignored, store unchanged.
REQ-038 Start with 5-instr program, stop on 2nd issued cycle (pc_o=1) -> idle instruction next cycle, READY; restart -> mem[0] again.
REQ-039 start and clear asserted same cycle in READY -> IDLE, prog_len_o 0, instr_o idle, busy 0.
REQ-040 reset asserted mid-RUN at pc_o=2 -> next cycle IDLE, instr_o idle, pc_o 0, load_ready 1; bench drives CPU high_low_cpu in loop and checks no register write after reset.
